// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells used by the serial adder datapath.
// half_adder: in1,in2 -> sum,carry; full_adder: in1,in2,cin -> sum,carry.
module half_adder (
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic carry
);

  assign sum   = in1 ^ in2;
  assign carry = in1 & in2;

endmodule

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .in1  (in1),
    .in2  (in2),
    .sum  (s1),
    .carry(c1)
  );

  half_adder u_ha1 (
    .in1  (s1),
    .in2  (cin),
    .sum  (sum),
    .carry(c2)
  );

  assign carry = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, WIDTH clocks per addition.
// Ports: clk, rst, start, in1, in2 -> busy, done, sum, carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  // carry doubles as the running carry flop between bit slices
  full_adder u_fa (
    .in1  (a[0]),
    .in2  (b[0]),
    .cin  (carry),
    .sum  (s_bit),
    .carry(c_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a     <= in1;
            b     <= in2;
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        RUN: begin
          // LSB-first result enters at the MSB end
          sum   <= {s_bit, sum[WIDTH-1:1]};
          a     <= a >> 1;
          b     <= b >> 1;
          carry <= c_bit;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
